// File: rtl/auto_exposure_ctrl.sv
// Closed-loop exposure controller: steps a saturating sensor gain toward a target
// intensity window once per frame, then waits for the sensor to apply the new gain.
module auto_exposure_ctrl #(
    parameter int SUM_W       = 32,
    parameter int GAIN_W      = 8,
    parameter int GAIN_INIT   = 16,
    parameter int GAIN_MIN    = 1,
    parameter int GAIN_MAX    = 255,
    parameter int SKIP_FRAMES = 2,
    parameter int LOCK_FRAMES = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable_i,
    input  logic [SUM_W-1:0]  sum_i,
    input  logic              sum_valid_i,
    input  logic [SUM_W-1:0]  target_lo_i,
    input  logic [SUM_W-1:0]  target_hi_i,
    input  logic [3:0]        step_i,
    output logic [GAIN_W-1:0] gain_o,
    output logic              gain_update_o,
    output logic              locked_o,
    output logic              busy_o
);

    localparam int EXT_W  = GAIN_W + 1;
    localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam int LOCK_W = $clog2(LOCK_FRAMES + 1);

    localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(SKIP_FRAMES);
    localparam logic [LOCK_W-1:0] LOCK_SAT  = LOCK_W'(LOCK_FRAMES);
    localparam logic [GAIN_W-1:0] G_MIN     = GAIN_W'(GAIN_MIN);
    localparam logic [GAIN_W-1:0] G_MAX     = GAIN_W'(GAIN_MAX);
    localparam logic [GAIN_W-1:0] G_INIT    = GAIN_W'(GAIN_INIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EVAL   = 2'd2
    } state_t;

    // With no frames to discard, a gain change re-evaluates on the very next frame.
    localparam state_t AFTER_CHANGE = (SKIP_FRAMES == 0) ? EVAL : SETTLE;

    state_t            state_q, state_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic              gain_update_q, gain_update_d;
    logic              locked_q, locked_d;
    logic              busy_q, busy_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [LOCK_W-1:0] lock_q, lock_d;

    // Candidate gains, computed one bit wider so neither direction can wrap.
    logic [EXT_W-1:0]  gain_ext, step_ext, inc_sum;
    logic [GAIN_W-1:0] cand_up, cand_dn, cand;
    logic [LOCK_W-1:0] lock_inc;
    logic              too_bright, too_dark;

    always_comb begin
        gain_ext = {1'b0, gain_q};
        step_ext = EXT_W'(step_i);
        inc_sum  = gain_ext + step_ext;

        cand_up = (inc_sum > EXT_W'(GAIN_MAX)) ? G_MAX : inc_sum[GAIN_W-1:0];
        if (gain_ext < step_ext + EXT_W'(GAIN_MIN)) begin
            cand_dn = G_MIN;
        end else begin
            cand_dn = gain_q - GAIN_W'(step_i);
        end

        too_bright = (sum_i > target_hi_i);
        too_dark   = !too_bright && (sum_i < target_lo_i);
        cand       = too_bright ? cand_dn : cand_up;
        lock_inc   = (lock_q == LOCK_SAT) ? lock_q : lock_q + 1'b1;
    end

    // NOTE: every output of this block gets a default first; a path that skips an
    // assignment would otherwise infer a latch holding the previous value.
    always_comb begin
        state_d       = state_q;
        gain_d        = gain_q;
        gain_update_d = 1'b0;
        locked_d      = locked_q;
        skip_d        = skip_q;
        lock_d        = lock_q;

        if (!enable_i) begin
            // Disable overrides everything, including a frame arriving on this edge.
            state_d  = IDLE;
            locked_d = 1'b0;
            lock_d   = '0;
            skip_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    locked_d = 1'b0;
                    lock_d   = '0;
                    skip_d   = SKIP_LOAD;
                    state_d  = AFTER_CHANGE;
                end
                SETTLE: begin
                    if (sum_valid_i) begin
                        skip_d = skip_q - 1'b1;
                        if (skip_q <= SKIP_W'(1)) begin
                            skip_d  = '0;
                            state_d = EVAL;
                        end
                    end
                end
                EVAL: begin
                    if (sum_valid_i) begin
                        if (too_bright || too_dark) begin
                            lock_d   = '0;
                            locked_d = 1'b0;
                            if (cand != gain_q) begin
                                gain_d        = cand;
                                gain_update_d = 1'b1;
                                skip_d        = SKIP_LOAD;
                                state_d       = AFTER_CHANGE;
                            end
                        end else begin
                            lock_d   = lock_inc;
                            locked_d = (lock_inc == LOCK_SAT);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == SETTLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            gain_q        <= G_INIT;
            gain_update_q <= 1'b0;
            locked_q      <= 1'b0;
            busy_q        <= 1'b0;
            skip_q        <= '0;
            lock_q        <= '0;
        end else begin
            state_q       <= state_d;
            gain_q        <= gain_d;
            gain_update_q <= gain_update_d;
            locked_q      <= locked_d;
            busy_q        <= busy_d;
            skip_q        <= skip_d;
            lock_q        <= lock_d;
        end
    end

    assign gain_o        = gain_q;
    assign gain_update_o = gain_update_q;
    assign locked_o      = locked_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_auto_exposure_ctrl.sv
// Directed bench for auto_exposure_ctrl: a per-cycle vector table for skip and
// low-clamp behaviour, then hand sequences for climb/high-clamp, lock, disable, reset.
module tb_auto_exposure_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable_i;
    logic [31:0] sum_i;
    logic        sum_valid_i;
    logic [31:0] target_lo_i;
    logic [31:0] target_hi_i;
    logic [3:0]  step_i;
    logic [7:0]  gain_o;
    logic        gain_update_o;
    logic        locked_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    auto_exposure_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable_i     (enable_i),
        .sum_i        (sum_i),
        .sum_valid_i  (sum_valid_i),
        .target_lo_i  (target_lo_i),
        .target_hi_i  (target_hi_i),
        .step_i       (step_i),
        .gain_o       (gain_o),
        .gain_update_o(gain_update_o),
        .locked_o     (locked_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic        en;
        logic        sv;
        logic [31:0] sum;
        logic [3:0]  step;
        logic [7:0]  g;
        logic        upd;
        logic        lk;
        logic        bsy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] g, input logic upd,
                              input logic lk, input logic bsy);
        check({tag, ".gain"},   32'(gain_o),        32'(g));
        check({tag, ".update"}, 32'(gain_update_o), 32'(upd));
        check({tag, ".locked"}, 32'(locked_o),      32'(lk));
        check({tag, ".busy"},   32'(busy_o),        32'(bsy));
    endtask

    // Drive one cycle's inputs on the falling edge; outputs are sampled 1 ns after the rise.
    task automatic cycle(input logic en, input logic sv, input logic [31:0] sum, input logic [3:0] step);
        @(negedge clk);
        enable_i    = en;
        sum_valid_i = sv;
        sum_i       = sum;
        step_i      = step;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic sv, input logic [31:0] sum, input logic [3:0] step,
                       input logic [7:0] g, input logic upd, input logic lk, input logic bsy);
        vec_t v;
        v.en = en; v.sv = sv; v.sum = sum; v.step = step;
        v.g = g; v.upd = upd; v.lk = lk; v.bsy = bsy;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] exp_g;

        //   en sv sum   step  gain upd lk busy
        add(1, 0,    0,  4,    16, 0, 0, 1);  // enable -> SETTLE
        add(1, 1,  500,  4,    16, 0, 0, 1);  // skip 1 ignored
        add(1, 1,  500,  4,    16, 0, 0, 0);  // skip 2 ignored -> EVAL
        add(1, 1,  500,  4,    20, 1, 0, 1);  // dark: 16 -> 20
        add(1, 0,    0,  4,    20, 0, 0, 1);  // pulse one cycle wide
        add(1, 1, 3000,  4,    20, 0, 0, 1);
        add(1, 1, 3000,  4,    20, 0, 0, 0);  // back-to-back frames
        add(1, 1, 3000, 15,     5, 1, 0, 1);  // bright: 20 -> 5
        add(1, 1, 3000, 15,     5, 0, 0, 1);
        add(1, 1, 3000, 15,     5, 0, 0, 0);
        add(1, 1, 3000,  2,     3, 1, 0, 1);  // 5 -> 3
        add(1, 1, 3000,  4,     3, 0, 0, 1);
        add(1, 1, 3000,  4,     3, 0, 0, 0);
        add(1, 1, 3000,  4,     1, 1, 0, 1);  // 3-4 clamps to GAIN_MIN
        add(1, 1, 3000,  4,     1, 0, 0, 1);
        add(1, 1, 3000,  4,     1, 0, 0, 0);
        add(1, 1, 3000,  4,     1, 0, 0, 0);  // already at min: no pulse, stay EVAL
        add(1, 0,    0,  4,     1, 0, 0, 0);

        resetn      = 1'b0;
        enable_i    = 1'b0;
        sum_valid_i = 1'b0;
        sum_i       = '0;
        step_i      = 4'd4;
        target_lo_i = 32'd1000;
        target_hi_i = 32'd2000;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 8'd16, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].en, vecs[i].sv, vecs[i].sum, vecs[i].step);
            check_outs($sformatf("vec%0d", i), vecs[i].g, vecs[i].upd, vecs[i].lk, vecs[i].bsy);
        end

        // Climb from 1 to 253 in steps of 12, each change followed by two skipped frames.
        exp_g = 8'd1;
        for (int i = 0; i < 21; i++) begin
            cycle(1, 1, 10, 12);
            exp_g = exp_g + 8'd12;
            check_outs($sformatf("climb%0d", i), exp_g, 1'b1, 1'b0, 1'b1);
            cycle(1, 1, 10, 12);
            check_outs($sformatf("climb%0d_s1", i), exp_g, 1'b0, 1'b0, 1'b1);
            cycle(1, 1, 10, 12);
            check_outs($sformatf("climb%0d_s2", i), exp_g, 1'b0, 1'b0, 1'b0);
        end

        cycle(1, 1, 10, 4);
        check_outs("clamp_hi", 8'd255, 1'b1, 1'b0, 1'b1);
        cycle(1, 1, 10, 4);
        cycle(1, 1, 10, 4);
        check_outs("clamp_hi_settled", 8'd255, 1'b0, 1'b0, 1'b0);
        cycle(1, 1, 10, 4);
        check_outs("clamp_hi_nowrap", 8'd255, 1'b0, 1'b0, 1'b0);

        cycle(1, 1, 1500, 4);
        check_outs("lock1", 8'd255, 1'b0, 1'b0, 1'b0);
        cycle(1, 1, 1500, 4);
        check_outs("lock2", 8'd255, 1'b0, 1'b0, 1'b0);
        cycle(1, 1, 1500, 4);
        check_outs("lock3", 8'd255, 1'b0, 1'b1, 1'b0);
        cycle(1, 1, 1000, 4);
        check_outs("lock4_edge_lo", 8'd255, 1'b0, 1'b1, 1'b0);
        cycle(1, 1, 2500, 4);
        check_outs("unlock_dec", 8'd251, 1'b1, 1'b0, 1'b1);

        // Drop enable in SETTLE with a frame on the same edge.
        cycle(0, 1, 500, 4);
        check_outs("disable", 8'd251, 1'b0, 1'b0, 1'b0);
        cycle(0, 1, 500, 4);
        check_outs("disabled_hold", 8'd251, 1'b0, 1'b0, 1'b0);
        cycle(1, 0, 0, 4);
        check_outs("reenable", 8'd251, 1'b0, 1'b0, 1'b1);
        cycle(1, 1, 500, 4);
        check_outs("reskip1", 8'd251, 1'b0, 1'b0, 1'b1);
        cycle(1, 1, 500, 4);
        check_outs("reskip2", 8'd251, 1'b0, 1'b0, 1'b0);
        cycle(1, 1, 500, 4);
        check_outs("reeval", 8'd255, 1'b1, 1'b0, 1'b1);

        // Async reset between edges, while gain_update and busy are high.
        #2;
        resetn = 1'b0;
        #1;
        check_outs("async_reset", 8'd16, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        enable_i    = 1'b0;
        sum_valid_i = 1'b0;
        resetn      = 1'b1;
        @(posedge clk);
        #1;
        check_outs("post_reset", 8'd16, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
